// File: rtl/wallace_mult_pipe.sv
// Pipelined signed/unsigned WIDTH x WIDTH multiplier: operand register, Baugh-Wooley
// partial products, carry-save (Wallace) reduction spread over STAGES ranks, final CPA.
module wallace_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               out_signed
);
  localparam int PW  = 2 * WIDTH;
  localparam int NR  = WIDTH + 1;                      // WIDTH product rows + sign-correction row
  localparam int NRK = (STAGES > 1) ? STAGES - 1 : 1;

  typedef logic [NR-1:0][PW-1:0] rows_t;

  // Row count left after k carry-save levels, starting from NR rows.
  function automatic int rows_after(input int k);
    int n;
    n = NR;
    for (int i = 0; i < k; i++) begin
      if (n > 2) n = 2 * (n / 3) + n % 3;
    end
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = NR;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + n % 3;
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int LVLS = num_levels();
  localparam int LPS  = (LVLS + STAGES - 1) / STAGES;  // carry-save levels per rank

  // Signed mode inverts the cross terms against the sign bits and adds 2^W + 2^(2W-1).
  function automatic rows_t gen_pp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic sg);
    rows_t r;
    logic  bit_v;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        bit_v = x[j] & y[i];
        if (sg && ((i == WIDTH - 1) != (j == WIDTH - 1))) bit_v = ~bit_v;
        r[i][i+j] = bit_v;
      end
    end
    if (sg) begin
      r[WIDTH][WIDTH]  = 1'b1;
      r[WIDTH][PW-1]   = 1'b1;
    end
    return r;
  endfunction

  // One 3:2 level over the first n rows; leftover rows pass through, result is front-packed.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    k;
    o = '0;
    k = 0;
    for (int g = 0; g < NR / 3; g++) begin
      if (g < n / 3) begin
        o[k]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        o[k+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
        k = k + 2;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (i >= 3 * (n / 3) && i < n) begin
        o[k] = r[i];
        k = k + 1;
      end
    end
    return o;
  endfunction

  // Handshake: a beat moves on an edge where valid && ready. The whole pipe freezes while
  // out_valid && !out_ready; ready never depends on valid, and valid never waits for ready.
  logic [STAGES:0]   vld_q, vld_d;
  logic [STAGES:0]   sgn_q, sgn_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  rows_t             rk_q [NRK];
  rows_t             rk_d [NRK];
  logic [PW-1:0]     p_q, p_d;
  logic              stall;

  assign stall      = vld_q[STAGES] & ~out_ready;
  assign in_ready   = ~stall;
  assign out_valid  = vld_q[STAGES];
  assign out_signed = sgn_q[STAGES];
  assign p          = p_q;

  // Data ranks load only under a valid beat, so p and out_signed never change on bubbles.
  always_comb begin
    rows_t r;
    vld_d = vld_q;
    sgn_d = sgn_q;
    a_d   = a_q;
    b_d   = b_q;
    rk_d  = rk_q;
    p_d   = p_q;
    r     = '0;
    if (!stall) begin
      vld_d = {vld_q[STAGES-1:0], in_valid};
      if (in_valid) begin
        a_d      = a;
        b_d      = b;
        sgn_d[0] = in_signed;
      end
      for (int s = 0; s < STAGES; s++) begin
        if (vld_q[s]) begin
          sgn_d[s+1] = sgn_q[s];
          if (s == 0) r = gen_pp(a_q, b_q, sgn_q[0]);
          else        r = rk_q[(s > 0) ? s - 1 : 0];
          for (int l = 0; l < LPS; l++) r = csa_level(r, rows_after(s * LPS + l));
          if (s == STAGES - 1) p_d = r[0] + r[1];
          else                 rk_d[(s < NRK) ? s : 0] = r;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      sgn_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      for (int i = 0; i < NRK; i++) rk_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      sgn_q <= sgn_d;
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      rk_q  <= rk_d;
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed bench for wallace_mult_pipe: an 8-bit and a 4-bit instance, both three stages deep.
module tb_wallace_mult_pipe;
  localparam int ST = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8, ir8, is8, ov8, or8, os8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv4, ir4, is4, ov4, or4, os4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int n_chk;
  int n_pass;

  logic [16:0] exp8_q[$];
  logic [8:0]  exp4_q[$];
  logic [7:0]  sa8[$], sb8[$];
  logic        ss8[$];
  logic [3:0]  sa4[$], sb4[$];
  logic        ss4[$];

  wallace_mult_pipe #(.WIDTH(8), .STAGES(ST)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_signed(is8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .p(p8), .out_signed(os8)
  );

  wallace_mult_pipe #(.WIDTH(4), .STAGES(ST)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_signed(is4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .p(p4), .out_signed(os4)
  );

  function automatic logic [16:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] sp;
    logic [15:0]        up;
    sp = $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
    up = {8'b0, x} * {8'b0, y};
    if (s) return {1'b1, sp};
    return {1'b0, up};
  endfunction

  function automatic logic [8:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
    logic signed [7:0] sp;
    logic [7:0]        up;
    sp = $signed({{4{x[3]}}, x}) * $signed({{4{y[3]}}, y});
    up = {4'b0, x} * {4'b0, y};
    if (s) return {1'b1, sp};
    return {1'b0, up};
  endfunction

  // Called and returning at 1 time unit after a rising edge.
  task automatic stream8(input int stall_pct, output int first_emit, output int last_emit);
    int          cyc;
    logic [16:0] e;
    cyc = 0;
    first_emit = -1;
    last_emit = -1;
    while ((sa8.size() > 0 || exp8_q.size() > 0) && cyc < 2000) begin
      if (sa8.size() > 0) begin
        iv8 = 1'b1; a8 = sa8[0]; b8 = sb8[0]; is8 = ss8[0];
      end else begin
        iv8 = 1'b0;
      end
      or8 = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
      @(negedge clk);
      if (iv8 && ir8) begin
        sa8.delete(0); sb8.delete(0); ss8.delete(0);
      end
      if (ov8 && or8) begin
        n_chk++;
        if (exp8_q.size() == 0) begin
          $display("FAIL w8_extra: got sgn=%0b p=%h with no beat outstanding", os8, p8);
        end else begin
          e = exp8_q.pop_front();
          if ({os8, p8} !== e)
            $display("FAIL w8_product: got sgn=%0b p=%h, expected sgn=%0b p=%h",
                     os8, p8, e[16], e[15:0]);
          else n_pass++;
        end
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    if (cyc >= 2000) begin
      n_chk++;
      $display("FAIL w8_timeout: %0d products still expected, got none", exp8_q.size());
      exp8_q.delete(); sa8.delete(); sb8.delete(); ss8.delete();
    end
  endtask

  task automatic stream4(input int stall_pct, output int first_emit, output int last_emit);
    int         cyc;
    logic [8:0] e;
    cyc = 0;
    first_emit = -1;
    last_emit = -1;
    while ((sa4.size() > 0 || exp4_q.size() > 0) && cyc < 3000) begin
      if (sa4.size() > 0) begin
        iv4 = 1'b1; a4 = sa4[0]; b4 = sb4[0]; is4 = ss4[0];
      end else begin
        iv4 = 1'b0;
      end
      or4 = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
      @(negedge clk);
      if (iv4 && ir4) begin
        sa4.delete(0); sb4.delete(0); ss4.delete(0);
      end
      if (ov4 && or4) begin
        n_chk++;
        if (exp4_q.size() == 0) begin
          $display("FAIL w4_extra: got sgn=%0b p=%h with no beat outstanding", os4, p4);
        end else begin
          e = exp4_q.pop_front();
          if ({os4, p4} !== e)
            $display("FAIL w4_product: got sgn=%0b p=%h, expected sgn=%0b p=%h",
                     os4, p4, e[8], e[7:0]);
          else n_pass++;
        end
        if (first_emit < 0) first_emit = cyc;
        last_emit = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    if (cyc >= 3000) begin
      n_chk++;
      $display("FAIL w4_timeout: %0d products still expected, got none", exp4_q.size());
      exp4_q.delete(); sa4.delete(); sb4.delete(); ss4.delete();
    end
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if ({ov8, os8, p8} !== 18'h0) $display("FAIL rst_w8_out: got v=%0b s=%0b p=%h, expected 0/0/0000", ov8, os8, p8); else n_pass++;
    n_chk++; if ({ov4, os4, p4} !== 10'h0) $display("FAIL rst_w4_out: got v=%0b s=%0b p=%h, expected 0/0/00", ov4, os4, p4); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (ir8 !== 1'b1) $display("FAIL rst_w8_in_ready: got %0b, expected 1", ir8); else n_pass++;
    n_chk++; if (ir4 !== 1'b1) $display("FAIL rst_w4_in_ready: got %0b, expected 1", ir4); else n_pass++;
    n_chk++; if (ov8 !== 1'b0) $display("FAIL rst_w8_valid_after: got %0b, expected 0", ov8); else n_pass++;
  endtask

  task automatic test_w4_directed;
    logic [3:0] ta [6];
    logic [3:0] tb [6];
    logic       ts [6];
    logic [8:0] te [6];
    int fe, le;
    ta = '{4'hE, 4'hF, 4'h0, 4'h8, 4'hF, 4'h7};
    tb = '{4'hA, 4'hF, 4'h0, 4'h8, 4'hF, 4'h8};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    te = '{9'h08C, 9'h0E1, 9'h000, 9'h140, 9'h101, 9'h1C8};
    for (int i = 0; i < 6; i++) begin
      sa4.push_back(ta[i]); sb4.push_back(tb[i]); ss4.push_back(ts[i]);
      exp4_q.push_back(te[i]);
      stream4(0, fe, le);
      n_chk++;
      if (fe !== ST + 1) $display("FAIL w4_latency: vector %0d emitted at loop cycle %0d, expected %0d", i, fe, ST + 1);
      else n_pass++;
    end
  endtask

  task automatic test_w8_mixed;
    logic [7:0]  ta [8];
    logic [7:0]  tb [8];
    logic        ts [8];
    logic [16:0] te [8];
    int fe, le;
    ta = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h00, 8'h01};
    tb = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h80};
    ts = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    te = '{17'h10001, 17'h0FE01, 17'h14000, 17'h04000, 17'h1C080, 17'h03F80, 17'h10000, 17'h1FF80};
    for (int i = 0; i < 8; i++) begin
      sa8.push_back(ta[i]); sb8.push_back(tb[i]); ss8.push_back(ts[i]);
      exp8_q.push_back(te[i]);
    end
    stream8(0, fe, le);
    n_chk++;
    if (le - fe !== 7) $display("FAIL w8_mixed_spacing: span %0d cycles, expected 7", le - fe);
    else n_pass++;
  endtask

  task automatic test_streaming;
    logic [7:0] x, y;
    logic       s;
    int fe, le;
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom_range(255)); y = 8'($urandom_range(255)); s = 1'($urandom_range(1));
      sa8.push_back(x); sb8.push_back(y); ss8.push_back(s);
      exp8_q.push_back(ref8(x, y, s));
    end
    stream8(0, fe, le);
    n_chk++; if (fe !== ST + 1) $display("FAIL stream_first: got loop cycle %0d, expected %0d", fe, ST + 1); else n_pass++;
    n_chk++; if (le !== ST + 16) $display("FAIL stream_last: got loop cycle %0d, expected %0d", le, ST + 16); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [7:0]  ta [5];
    logic [7:0]  tb [5];
    logic        ts [5];
    logic [16:0] te [5];
    int fe, le;
    ta = '{8'h12, 8'hF0, 8'hC8, 8'h9C, 8'hFF};
    tb = '{8'h34, 8'h0F, 8'h05, 8'h9C, 8'h02};
    ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    te = '{17'h003A8, 17'h1FF10, 17'h003E8, 17'h12710, 17'h1FFFE};
    or8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv8 = 1'b1; a8 = ta[i]; b8 = tb[i]; is8 = ts[i];
      @(posedge clk); #1;
    end
    iv8 = 1'b1; a8 = ta[4]; b8 = tb[4]; is8 = ts[4];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++; if (ir8 !== 1'b0) $display("FAIL bp_in_ready: cycle %0d got %0b, expected 0", k, ir8); else n_pass++;
      n_chk++; if (ov8 !== 1'b1) $display("FAIL bp_valid: cycle %0d got %0b, expected 1", k, ov8); else n_pass++;
      n_chk++; if ({os8, p8} !== te[0]) $display("FAIL bp_hold: cycle %0d got sgn=%0b p=%h, expected sgn=0 p=03a8", k, os8, p8); else n_pass++;
      @(posedge clk); #1;
    end
    sa8.push_back(ta[4]); sb8.push_back(tb[4]); ss8.push_back(ts[4]);
    for (int i = 0; i < 5; i++) exp8_q.push_back(te[i]);
    stream8(0, fe, le);
    n_chk++; if (le - fe !== 4) $display("FAIL bp_drain_span: got %0d cycles, expected 4", le - fe); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int fe, le;
    or8 = 1'b1;
    is8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv8 = 1'b1; a8 = 8'h91 + 8'(i); b8 = 8'h23;
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    n_chk++; if (ov8 !== 1'b1) $display("FAIL rmid_pre_valid: got %0b, expected 1", ov8); else n_pass++;
    #2; rst_n = 1'b0; #1;
    n_chk++; if (ov8 !== 1'b0) $display("FAIL rmid_valid: got %0b, expected 0", ov8); else n_pass++;
    n_chk++; if (p8 !== 16'h0) $display("FAIL rmid_p: got %h, expected 0000", p8); else n_pass++;
    n_chk++; if (os8 !== 1'b0) $display("FAIL rmid_sgn: got %0b, expected 0", os8); else n_pass++;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (ov8 !== 1'b0) $display("FAIL rmid_stale: got valid %0b, expected 0", ov8); else n_pass++;
    sa8.push_back(8'h5A); sb8.push_back(8'hC3); ss8.push_back(1'b1);
    exp8_q.push_back(17'h1EA8E);
    stream8(0, fe, le);
    n_chk++; if (fe !== ST + 1) $display("FAIL rmid_latency: got loop cycle %0d, expected %0d", fe, ST + 1); else n_pass++;
  endtask

  task automatic test_exhaustive_w4;
    int fe, le;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          sa4.push_back(4'(x)); sb4.push_back(4'(y)); ss4.push_back(1'(s));
          exp4_q.push_back(ref4(4'(x), 4'(y), 1'(s)));
        end
      end
    end
    stream4(30, fe, le);
  endtask

  task automatic test_quiet;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++; if ({ov8, ov4} !== 2'b00) $display("FAIL quiet: got v8=%0b v4=%0b, expected 0/0", ov8, ov4); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    iv8 = 1'b0; is8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
    iv4 = 1'b0; is4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset;
    test_w4_directed;
    test_w8_mixed;
    test_streaming;
    test_backpressure;
    test_reset_mid;
    test_exhaustive_w4;
    test_quiet;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
